// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: sequences a bit-serial pattern detector from a word-level
// valid/ready interface. Accepts a word, clears the detector, shifts the word
// MSB-first, counts latency-corrected hits and returns the count.
// Optional build macro SEQ_CTRL_FIRST_POS_EN adds the first_pos output, which
// reports the bit index of the first counted hit (all-ones when none).
module seq_detect_ctrl #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 5,
    parameter int HIT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             det_clr,
    output logic             det_en,
    output logic             det_bit,
    input  logic             det_hit,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CNT_W-1:0] match_count
`ifdef SEQ_CTRL_FIRST_POS_EN
    ,
    output logic [CNT_W-1:0] first_pos
`endif
);

    // Cycle counter spans the shift and drain phases: 0 .. WIDTH+HIT_LAT-1.
    localparam int C_W = $clog2(WIDTH + HIT_LAT + 1);
    localparam logic [C_W-1:0] C_LAST_SHIFT = C_W'(WIDTH - 1);
    localparam logic [C_W-1:0] C_LAST_DRAIN = C_W'(WIDTH + HIT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [C_W-1:0]   c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             det_clr_q;
    logic             det_en_q;
    logic             det_bit_q;
    logic             done_valid_q;
    logic             hit_cnt;

    // Saturating increment; the count cannot reach all-ones with legal
    // parameters, so this only guards against misconfiguration.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A hit counts only while scanning and once the detector latency has
    // elapsed; earlier hits belong to the detector's pre-clear history.
    always_comb begin
        hit_cnt = 1'b0;
        if ((state_q == S_SHIFT || state_q == S_DRAIN) && det_hit &&
            (int'(c_q) >= HIT_LAT))
            hit_cnt = 1'b1;
    end

`ifdef SEQ_CTRL_FIRST_POS_EN
    logic [CNT_W-1:0] fpos_q;
    logic [CNT_W-1:0] hit_idx;

    // Bit index that the current hit belongs to.
    always_comb begin
        hit_idx = CNT_W'(int'(c_q) - HIT_LAT);
    end

    // First-hit position: preset to all-ones at accept, captured on first hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpos_q <= '0;
        end else if (state_q == S_IDLE && in_valid) begin
            fpos_q <= {CNT_W{1'b1}};
        end else if (hit_cnt && cnt_q == '0) begin
            fpos_q <= hit_idx;
        end
    end

    assign first_pos = fpos_q;
`endif

    // Controller FSM with registered handshake and detector outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
            det_clr_q    <= 1'b0;
            det_en_q     <= 1'b0;
            det_bit_q    <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q     <= in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        det_clr_q  <= 1'b1;
                        state_q    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    det_clr_q <= 1'b0;
                    det_en_q  <= 1'b1;
                    det_bit_q <= word_q[WIDTH-1];
                    word_q    <= word_q << 1;
                    c_q       <= '0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    c_q <= c_q + 1'b1;
                    if (c_q == C_LAST_SHIFT) begin
                        det_en_q  <= 1'b0;
                        det_bit_q <= 1'b0;
                        if (HIT_LAT > 0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            done_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end
                    end else begin
                        det_bit_q <= word_q[WIDTH-1];
                        word_q    <= word_q << 1;
                    end
                end
                S_DRAIN: begin
                    c_q <= c_q + 1'b1;
                    if (c_q == C_LAST_DRAIN) begin
                        done_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (hit_cnt)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    assign in_ready    = in_ready_q;
    assign det_clr     = det_clr_q;
    assign det_en      = det_en_q;
    assign det_bit     = det_bit_q;
    assign done_valid  = done_valid_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a HIT_LAT=1 instance driven by a 10101 detector
// model, plus a HIT_LAT=0 instance whose detector reports a hit on every bit.
module tb_seq_detect_ctrl;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // HIT_LAT = 1 instance
    logic          in_valid, in_ready, det_clr, det_en, det_bit, det_hit;
    logic          done_valid, done_ready;
    logic [W-1:0]  in_data;
    logic [4:0]    match_count;
    // HIT_LAT = 0 instance
    logic          in_valid0, in_ready0, det_clr0, det_en0, det_bit0, det_hit0;
    logic          done_valid0, done_ready0;
    logic [W-1:0]  in_data0;
    logic [4:0]    match_count0;
`ifdef SEQ_CTRL_FIRST_POS_EN
    logic [4:0]    first_pos, first_pos0;
`endif

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(5), .HIT_LAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .det_clr(det_clr), .det_en(det_en),
        .det_bit(det_bit), .det_hit(det_hit), .done_valid(done_valid),
        .done_ready(done_ready), .match_count(match_count)
`ifdef SEQ_CTRL_FIRST_POS_EN
        , .first_pos(first_pos)
`endif
    );

    seq_detect_ctrl #(.WIDTH(W), .CNT_W(5), .HIT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data0), .det_clr(det_clr0), .det_en(det_en0),
        .det_bit(det_bit0), .det_hit(det_hit0), .done_valid(done_valid0),
        .done_ready(done_ready0), .match_count(match_count0)
`ifdef SEQ_CTRL_FIRST_POS_EN
        , .first_pos(first_pos0)
`endif
    );

    // Behavioural detector: flags 10101 over the last five shifted bits,
    // reported one cycle later.
    logic [4:0] hist;
    logic       model_hit;
    logic       force_on, force_val;
    always @(posedge clk) begin
        if (det_clr) begin
            hist      <= '0;
            model_hit <= 1'b0;
        end else begin
            if (det_en) hist <= {hist[3:0], det_bit};
            model_hit <= det_en && ({hist[3:0], det_bit} == 5'b10101);
        end
    end
    assign det_hit  = force_on ? force_val : model_hit;
    assign det_hit0 = det_en0;

    // Record the serial bit stream of the current word.
    logic bitq[$];
    always @(negedge clk) begin
        if (det_clr) bitq.delete();
        else if (det_en) bitq.push_back(det_bit);
    end

    // Reference: count 10101 windows over the MSB-first bit stream.
    function automatic int ref_count(input logic [W-1:0] w, output int fp);
        int n;
        logic [4:0] win;
        n  = 0;
        fp = 31;
        for (int i = 4; i < W; i++) begin
            win = {w[W-1-(i-4)], w[W-1-(i-3)], w[W-1-(i-2)], w[W-1-(i-1)], w[W-1-i]};
            if (win == 5'b10101) begin
                n++;
                if (fp == 31) fp = i;
            end
        end
        return n;
    endfunction

    // Offer a word, wait for its result, release after rdly cycles.
    task automatic run_word(input logic [W-1:0] w, input int rdly, output int acc,
                            output int dcy, output logic [4:0] mc,
                            output logic [4:0] fp, output logic to);
        int n;
        to = 1'b0; acc = 0; dcy = 0; mc = '0; fp = '1;
        @(negedge clk);
        in_data = w; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) to = 1'b1;
        acc = cyc;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!done_valid && n < 100) begin @(negedge clk); n++; end
        if (!done_valid) to = 1'b1;
        dcy = cyc;
        mc  = match_count;
`ifdef SEQ_CTRL_FIRST_POS_EN
        fp  = first_pos;
`endif
        repeat (rdly) @(negedge clk);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({det_clr, det_en, det_bit, done_valid} !== 4'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000", {det_clr, det_en, det_bit, done_valid}); end
        checks++; if (match_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", match_count); end
`ifdef SEQ_CTRL_FIRST_POS_EN
        checks++; if (first_pos !== 5'd0) begin errors++; $display("FAIL reset_first_pos: got %0d want 0", first_pos); end
`endif
        checks++; if (in_ready0 !== 1'b1 || done_valid0 !== 1'b0) begin errors++; $display("FAIL reset_dut0: got %b%b want 10", in_ready0, done_valid0); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        logic [W-1:0] words [3];
        int acc, dcy, efp, ecnt;
        logic [4:0] mc, fp;
        logic to;
        logic [W-1:0] got;
        words[0] = 16'hA800; words[1] = 16'hAAAA; words[2] = 16'h0015;
        for (int k = 0; k < 3; k++) begin
            run_word(words[k], 1, acc, dcy, mc, fp, to);
            ecnt = ref_count(words[k], efp);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout w=%h: got %b want 0", words[k], to); end
            checks++; if (mc !== 5'(ecnt)) begin errors++; $display("FAIL single_count w=%h: got %0d want %0d", words[k], mc, ecnt); end
`ifdef SEQ_CTRL_FIRST_POS_EN
            checks++; if (fp !== 5'(efp)) begin errors++; $display("FAIL single_first_pos w=%h: got %0d want %0d", words[k], fp, efp); end
`endif
            checks++; if (dcy - acc !== W + 3) begin errors++; $display("FAIL single_latency w=%h: got %0d want %0d", words[k], dcy - acc, W + 3); end
            got = '0;
            for (int i = 0; i < bitq.size() && i < W; i++) got[W-1-i] = bitq[i];
            checks++; if (bitq.size() != W || got !== words[k]) begin errors++; $display("FAIL single_bits: got %h (%0d bits) want %h", got, bitq.size(), words[k]); end
            checks++; if (match_count !== 5'(ecnt)) begin errors++; $display("FAIL single_hold_idle: got %0d want %0d", match_count, ecnt); end
        end
    endtask

    task automatic test_stale;
        int n;
        force_on = 1'b1; force_val = 1'b0;
        @(negedge clk);
        in_data = 16'h0000; in_valid = 1'b1;
        n = 0;
        while (!det_clr && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        force_val = 1'b1;
        @(posedge clk); @(posedge clk); #1 force_val = 1'b0;
        n = 0;
        while (!done_valid && n < 100) begin @(negedge clk); n++; end
        checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL stale_done: got %b want 1", done_valid); end
        checks++; if (match_count !== 5'd0) begin errors++; $display("FAIL stale_count: got %0d want 0", match_count); end
`ifdef SEQ_CTRL_FIRST_POS_EN
        checks++; if (first_pos !== 5'd31) begin errors++; $display("FAIL stale_first_pos: got %0d want 31", first_pos); end
`endif
        done_ready = 1'b1; @(negedge clk); done_ready = 1'b0;
        force_on = 1'b0;
    endtask

    task automatic test_backpressure;
        int n, acc, acc2;
        @(negedge clk);
        in_data = 16'hAAAA; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        acc = cyc;
        @(posedge clk); #1 in_data = 16'hA800;
        @(negedge clk);
        n = 0;
        while (!done_valid && n < 100) begin @(negedge clk); n++; end
        checks++; if (cyc - acc !== W + 3) begin errors++; $display("FAIL bp_latency: got %0d want %0d", cyc - acc, W + 3); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (done_valid !== 1'b1 || in_ready !== 1'b0 || match_count !== 5'd6 || det_clr !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: got dv=%b rdy=%b cnt=%0d clr=%b want 1 0 6 0", i, done_valid, in_ready, match_count, det_clr);
            end
            @(negedge clk);
        end
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        acc2 = cyc;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++; if (det_clr !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got det_clr %b want 1", det_clr); end
        n = 0;
        while (!done_valid && n < 100) begin @(negedge clk); n++; end
        checks++; if (cyc - acc2 !== W + 3 || match_count !== 5'd1) begin errors++; $display("FAIL bp_second_word: got lat %0d cnt %0d want %0d 1", cyc - acc2, match_count, W + 3); end
        done_ready = 1'b1; @(negedge clk); done_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [W-1:0] w;
        int acc, dcy, efp, ecnt;
        logic [4:0] mc, fp;
        logic to;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1) w = W'($urandom);
            else w = 16'hAAAA ^ (W'(1) << $urandom_range(0, W - 1));
            run_word(w, $urandom_range(0, 3), acc, dcy, mc, fp, to);
            ecnt = ref_count(w, efp);
            checks++; if (to !== 1'b0 || dcy - acc !== W + 3) begin errors++; $display("FAIL rand_latency w=%h: got %0d to=%b want %0d", w, dcy - acc, to, W + 3); end
            checks++; if (mc !== 5'(ecnt)) begin errors++; $display("FAIL rand_count w=%h: got %0d want %0d", w, mc, ecnt); end
`ifdef SEQ_CTRL_FIRST_POS_EN
            checks++; if (fp !== 5'(efp)) begin errors++; $display("FAIL rand_first_pos w=%h: got %0d want %0d", w, fp, efp); end
`endif
        end
    endtask

    task automatic test_reset_mid;
        int n;
        @(negedge clk);
        in_data = 16'hFFFF; in_valid = 1'b1;
        n = 0;
        while (!det_clr && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if ({in_ready, det_clr, det_en, det_bit, done_valid} !== 5'b10000) begin errors++; $display("FAIL rstmid_outs: got %b want 10000", {in_ready, det_clr, det_en, det_bit, done_valid}); end
        checks++; if (match_count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", match_count); end
`ifdef SEQ_CTRL_FIRST_POS_EN
        checks++; if (first_pos !== 5'd0) begin errors++; $display("FAIL rstmid_first_pos: got %0d want 0", first_pos); end
`endif
        @(negedge clk); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_valid) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", n); end
        // Reset while a result is waiting must drop done_valid at once.
        in_data = 16'hA800; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        while (!done_valid && n < 100) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        checks++; if (done_valid !== 1'b0 || in_ready !== 1'b1 || match_count !== 5'd0) begin errors++; $display("FAIL rstdone_drop: got dv=%b rdy=%b cnt=%0d want 0 1 0", done_valid, in_ready, match_count); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hitlat0;
        int n, acc, first, hi;
        logic [4:0] mc, fp;
        first = -1; hi = 0; mc = '0; fp = '1;
        done_ready0 = 1'b1;
        @(negedge clk);
        in_data0 = 16'hFFFF; in_valid0 = 1'b1;
        n = 0;
        while (!in_ready0 && n < 50) begin @(negedge clk); n++; end
        acc = cyc;
        @(posedge clk); #1 in_valid0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_valid0) begin
                if (first < 0) begin
                    first = cyc;
                    mc = match_count0;
`ifdef SEQ_CTRL_FIRST_POS_EN
                    fp = first_pos0;
`endif
                end
                hi++;
            end
        end
        done_ready0 = 1'b0;
        checks++; if (first - acc !== W + 2) begin errors++; $display("FAIL hl0_latency: got %0d want %0d", first - acc, W + 2); end
        checks++; if (hi !== 1) begin errors++; $display("FAIL hl0_one_cycle_done: got %0d want 1", hi); end
        checks++; if (mc !== 5'd16) begin errors++; $display("FAIL hl0_count: got %0d want 16", mc); end
`ifdef SEQ_CTRL_FIRST_POS_EN
        checks++; if (fp !== 5'd0) begin errors++; $display("FAIL hl0_first_pos: got %0d want 0", fp); end
`endif
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL hl0_idle: got %b want 1", in_ready0); end
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; done_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; done_ready0 = 1'b0;
        force_on = 1'b0; force_val = 1'b0;
        test_reset();
        test_single();
        test_stale();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_hitlat0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
